// File: rtl/csr_bank.sv
// Control/status register bank between the peripheral bus and the QR accelerator core.
// It handles start/soft-clear pulses, busy/done tracking, a maskable IRQ and write-protected config registers.
module csr_bank #(
    parameter int CsrWidth  = 32,
    parameter int NumCfg    = 4,
    parameter int AddrWidth = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_wen_i,
    input  logic [AddrWidth-1:0]       req_addr_i,
    input  logic [CsrWidth-1:0]        req_wdata_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [CsrWidth-1:0]        rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic [NumCfg*CsrWidth-1:0] cfg_o,
    output logic                       start_o,
    output logic                       soft_clr_o,
    input  logic                       acc_done_i,
    output logic                       busy_o,
    output logic                       irq_o
);

    localparam logic [AddrWidth-1:0] AddrCore   = AddrWidth'(0);
    localparam logic [AddrWidth-1:0] AddrStatus = AddrWidth'(1);
    localparam logic [AddrWidth-1:0] AddrIrqEn  = AddrWidth'(2);

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                irqEn_q, irqEn_d;
    logic                irq_q, irq_d;
    logic                start_q, start_d;
    logic                softClr_q, softClr_d;
    logic                rspValid_q, rspValid_d;
    logic [CsrWidth-1:0] rspRdata_q, rspRdata_d;
    logic                rspErr_q, rspErr_d;
    logic [CsrWidth-1:0] cfg_q [NumCfg];
    logic [CsrWidth-1:0] cfg_d [NumCfg];
    logic                accept;
    logic                cfgHit;
    logic                doneSet;

    assign req_ready_o = !rspValid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign doneSet     = acc_done_i && busy_q;

    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        irqEn_d    = irqEn_q;
        cfg_d      = cfg_q;
        start_d    = 1'b0;
        softClr_d  = 1'b0;
        rspValid_d = rspValid_q && !rsp_ready_i;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        cfgHit     = 1'b0;

        if (doneSet) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (accept) begin
            rspValid_d = 1'b1;
            rspRdata_d = '0;
            rspErr_d   = 1'b0;
            if (req_addr_i == AddrCore) begin
                if (req_wen_i) begin
                    // Soft clear overrides a start requested in the same write.
                    if (req_wdata_i[1]) begin
                        softClr_d = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b0;
                    end else if (req_wdata_i[0]) begin
                        if (busy_q) begin
                            rspErr_d = 1'b1;
                        end else begin
                            start_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
            end else if (req_addr_i == AddrStatus) begin
                if (req_wen_i) begin
                    // A done event landing on the same edge beats the W1C.
                    if (req_wdata_i[1] && !doneSet) begin
                        done_d = 1'b0;
                    end
                end else begin
                    rspRdata_d = CsrWidth'({done_q, busy_q});
                end
            end else if (req_addr_i == AddrIrqEn) begin
                if (req_wen_i) begin
                    irqEn_d = req_wdata_i[0];
                end else begin
                    rspRdata_d = CsrWidth'(irqEn_q);
                end
            end else begin
                for (int k = 0; k < NumCfg; k++) begin
                    if (req_addr_i == AddrWidth'(3 + k)) begin
                        cfgHit = 1'b1;
                        if (req_wen_i) begin
                            if (busy_q) begin
                                rspErr_d = 1'b1;
                            end else begin
                                cfg_d[k] = req_wdata_i;
                            end
                        end else begin
                            rspRdata_d = cfg_q[k];
                        end
                    end
                end
                if (!cfgHit) begin
                    rspErr_d = 1'b1;
                end
            end
        end

        irq_d = done_q && irqEn_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            irqEn_q    <= 1'b0;
            irq_q      <= 1'b0;
            start_q    <= 1'b0;
            softClr_q  <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
            for (int k = 0; k < NumCfg; k++) begin
                cfg_q[k] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            irqEn_q    <= irqEn_d;
            irq_q      <= irq_d;
            start_q    <= start_d;
            softClr_q  <= softClr_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
            cfg_q      <= cfg_d;
        end
    end

    for (genvar g = 0; g < NumCfg; g++) begin : gCfgOut
        assign cfg_o[g*CsrWidth +: CsrWidth] = cfg_q[g];
    end

    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspRdata_q;
    assign rsp_err_o   = rspErr_q;
    assign start_o     = start_q;
    assign soft_clr_o  = softClr_q;
    assign busy_o      = busy_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_csr_bank.sv
// Directed self-checking bench for csr_bank with default parameters.
// The bench drives inputs on the falling edge and samples responses on the following falling edge.
module tb_csr_bank;

    logic         clk;
    logic         nrst;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         req_wen_i;
    logic [3:0]   req_addr_i;
    logic [31:0]  req_wdata_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [31:0]  rsp_rdata_o;
    logic         rsp_err_o;
    logic [127:0] cfg_o;
    logic         start_o;
    logic         soft_clr_o;
    logic         acc_done_i;
    logic         busy_o;
    logic         irq_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;

    csr_bank dut (
        .clk         (clk),
        .nrst        (nrst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_wen_i   (req_wen_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .cfg_o       (cfg_o),
        .start_o     (start_o),
        .soft_clr_o  (soft_clr_o),
        .acc_done_i  (acc_done_i),
        .busy_o      (busy_o),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One bus access with rsp_ready_i high; returns the response seen on the next falling edge.
    task automatic applyStimulus(input logic wen, input logic [3:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_wen_i   = wen;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_wen_i   = 1'b0;
        checkOutput("rsp_valid", 32'(rsp_valid_o), 32'd1);
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
    endtask

    typedef struct {
        logic        wen;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t burst [9];

    initial begin
        nrst        = 1'b0;
        req_valid_i = 1'b0;
        req_wen_i   = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        acc_done_i  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_irq", 32'(irq_o), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_cfg_zero", 32'(cfg_o != '0), 32'd0);
        nrst = 1'b1;

        for (int a = 1; a <= 6; a++) begin
            applyStimulus(1'b0, 4'(a), 32'd0, rd, er);
            checkOutput($sformatf("rst_read_%0d_data", a), rd, 32'd0);
            checkOutput($sformatf("rst_read_%0d_err", a), 32'(er), 32'd0);
        end

        applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, rd, er);
        checkOutput("cfg2_wr_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 4'd5, 32'd0, rd, er);
        checkOutput("cfg2_rd", rd, 32'hDEADBEEF);
        checkOutput("cfg_o_slice2", cfg_o[95:64], 32'hDEADBEEF);
        checkOutput("cfg_o_slice0", cfg_o[31:0], 32'd0);
        checkOutput("cfg_o_slice1", cfg_o[63:32], 32'd0);
        checkOutput("cfg_o_slice3", cfg_o[127:96], 32'd0);

        applyStimulus(1'b1, 4'd2, 32'hFFFF_FFFF, rd, er);
        applyStimulus(1'b0, 4'd2, 32'd0, rd, er);
        checkOutput("irqen_rd", rd, 32'd1);

        applyStimulus(1'b1, 4'd0, 32'h1, rd, er);
        checkOutput("start_err", 32'(er), 32'd0);
        checkOutput("start_pulse", 32'(start_o), 32'd1);
        checkOutput("start_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        checkOutput("start_pulse_end", 32'(start_o), 32'd0);
        checkOutput("busy_held", 32'(busy_o), 32'd1);

        applyStimulus(1'b1, 4'd3, 32'd5, rd, er);
        checkOutput("cfg_wp_err", 32'(er), 32'd1);
        checkOutput("cfg_wp_val", cfg_o[31:0], 32'd0);

        @(negedge clk);
        acc_done_i = 1'b1;
        @(negedge clk);
        acc_done_i = 1'b0;
        checkOutput("done_busy_clr", 32'(busy_o), 32'd0);
        applyStimulus(1'b0, 4'd1, 32'd0, rd, er);
        checkOutput("status_done", rd, 32'h2);
        checkOutput("irq_set", 32'(irq_o), 32'd1);

        applyStimulus(1'b1, 4'd1, 32'h2, rd, er);
        applyStimulus(1'b0, 4'd1, 32'd0, rd, er);
        checkOutput("status_w1c", rd, 32'd0);
        checkOutput("irq_clr", 32'(irq_o), 32'd0);

        applyStimulus(1'b1, 4'd0, 32'h1, rd, er);
        checkOutput("start2_pulse", 32'(start_o), 32'd1);
        applyStimulus(1'b1, 4'd0, 32'h1, rd, er);
        checkOutput("start_busy_err", 32'(er), 32'd1);
        checkOutput("start_busy_nopulse", 32'(start_o), 32'd0);
        checkOutput("start_busy_keep", 32'(busy_o), 32'd1);
        applyStimulus(1'b1, 4'd0, 32'h3, rd, er);
        checkOutput("sclr_err", 32'(er), 32'd0);
        checkOutput("sclr_pulse", 32'(soft_clr_o), 32'd1);
        checkOutput("sclr_nostart", 32'(start_o), 32'd0);
        checkOutput("sclr_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        checkOutput("sclr_pulse_end", 32'(soft_clr_o), 32'd0);
        applyStimulus(1'b0, 4'd1, 32'd0, rd, er);
        checkOutput("sclr_status", rd, 32'd0);

        // Backpressure: a second request waits while the first response is unconsumed.
        @(negedge clk);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_wen_i   = 1'b0;
        req_addr_i  = 4'd5;
        @(negedge clk);
        req_addr_i  = 4'd2;
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp_ready_%0d", c), 32'(req_ready_o), 32'd0);
            checkOutput($sformatf("bp_rdata_%0d", c), rsp_rdata_o, 32'hDEADBEEF);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        checkOutput("bp_second_valid", 32'(rsp_valid_o), 32'd1);
        checkOutput("bp_second_rdata", rsp_rdata_o, 32'd1);

        burst[0] = '{1'b1, 4'd4, 32'h1111_1111, 32'd0, 1'b0};
        burst[1] = '{1'b1, 4'd6, 32'hA5A5_A5A5, 32'd0, 1'b0};
        burst[2] = '{1'b0, 4'd4, 32'd0, 32'h1111_1111, 1'b0};
        burst[3] = '{1'b0, 4'd6, 32'd0, 32'hA5A5_A5A5, 1'b0};
        burst[4] = '{1'b0, 4'd5, 32'd0, 32'hDEAD_BEEF, 1'b0};
        burst[5] = '{1'b0, 4'd3, 32'd0, 32'd0, 1'b0};
        burst[6] = '{1'b1, 4'd2, 32'd0, 32'd0, 1'b0};
        burst[7] = '{1'b0, 4'd2, 32'd0, 32'd0, 1'b0};
        burst[8] = '{1'b0, 4'd9, 32'd0, 32'd0, 1'b1};
        for (int i = 0; i <= 9; i++) begin
            if (i > 0) begin
                checkOutput($sformatf("b2b_%0d_valid", i - 1), 32'(rsp_valid_o), 32'd1);
                checkOutput($sformatf("b2b_%0d_rdata", i - 1), rsp_rdata_o, burst[i-1].expRdata);
                checkOutput($sformatf("b2b_%0d_err", i - 1), 32'(rsp_err_o), 32'(burst[i-1].expErr));
            end
            if (i < 9) begin
                req_valid_i = 1'b1;
                req_wen_i   = burst[i].wen;
                req_addr_i  = burst[i].addr;
                req_wdata_i = burst[i].wdata;
                @(negedge clk);
            end
        end
        req_valid_i = 1'b0;

        for (int a = 7; a <= 15; a++) begin
            applyStimulus(1'b0, 4'(a), 32'd0, rd, er);
            checkOutput($sformatf("bad_%0d_err", a), 32'(er), 32'd1);
            checkOutput($sformatf("bad_%0d_data", a), rd, 32'd0);
        end

        applyStimulus(1'b1, 4'd0, 32'h1, rd, er);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_wen_i   = 1'b1;
        req_addr_i  = 4'd1;
        req_wdata_i = 32'h2;
        acc_done_i  = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        acc_done_i  = 1'b0;
        checkOutput("race_busy", 32'(busy_o), 32'd0);
        applyStimulus(1'b0, 4'd1, 32'd0, rd, er);
        checkOutput("race_done_wins", rd, 32'h2);

        applyStimulus(1'b1, 4'd0, 32'h2, rd, er);
        applyStimulus(1'b1, 4'd0, 32'h1, rd, er);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_wen_i   = 1'b0;
        req_addr_i  = 4'd1;
        @(negedge clk);
        req_valid_i = 1'b0;
        nrst = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("midrst_busy", 32'(busy_o), 32'd0);
        checkOutput("midrst_cfg", 32'(cfg_o != '0), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        applyStimulus(1'b0, 4'd1, 32'd0, rd, er);
        checkOutput("midrst_status", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_bank.md
Name: csr_bank

Overview:
- Parametrised control/status register bank, next generation of the accelerator CSR block. Sits between the peripheral bus and the QR accelerator core.
- Flat valid/ready request channel with a registered response channel carrying read data and an error flag.
- Provides start/soft-clear trigger pulses, busy tracking, a sticky done flag with W1C clear and a maskable interrupt.
- Provides NumCfg generic config registers that are write-protected while the core is busy.

Parameters:
- CsrWidth, 32, data width of every register and of the bus.
- NumCfg, 4, number of config registers; must be >= 1.
- AddrWidth, 4, word-address width; must satisfy 2^AddrWidth >= 3+NumCfg.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_wen_i  in  1  1=write, 0=read
- req_addr_i  in  AddrWidth  word address
- req_wdata_i  in  CsrWidth  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  CsrWidth  read data (0 for writes)
- rsp_err_o  out  1  access error
- cfg_o  out  NumCfg*CsrWidth  config registers; reg k in bits [k*CsrWidth +: CsrWidth]
- start_o  out  1  one-cycle start pulse to the core
- soft_clr_o  out  1  one-cycle core soft-clear pulse
- acc_done_i  in  1  core done pulse
- busy_o  out  1  core running
- irq_o  out  1  interrupt, level

Behaviour:
- Reset: clk is the only clock; nrst is asynchronous and active-low. On reset all registers, rsp_valid_o, rsp_rdata_o, rsp_err_o, start_o, soft_clr_o, busy_o and irq_o are 0; cfg_o is all zeros.
- Accept: a request is accepted when req_valid_i && req_ready_o.
- Ready: req_ready_o = !rsp_valid_o || rsp_ready_i. At most one response is outstanding; back-to-back accepts are allowed when rsp_ready_i=1.
- Response latency: rsp_valid_o rises the cycle after accept. rsp_rdata_o and rsp_err_o are held stable until rsp_valid_o && rsp_ready_i.
- Register map (word addresses):
  - 0 CORE. Write: bit0=start, bit1=soft_clr. Reads return 0.
  - 1 STATUS. Read: bit0=busy, bit1=done (sticky). Write: bit1 is W1C; other bits are ignored.
  - 2 IRQ_EN. RW, bit0 only; upper bits read 0.
  - 3..3+NumCfg-1 CFG[k]. RW, full width.
  - Any other address: rsp_err_o=1, rdata=0, no state change.
- Writes take effect on the accept edge; a read in the next request sees the new value.
- Start: an accepted write to CORE with bit0=1 while busy=0 gives start_o=1 for exactly one cycle (the cycle after accept) and sets busy=1 in that same cycle.
- Start while busy=1: the request is rejected with rsp_err_o=1, there is no pulse, and state is unchanged.
- Soft clear: CORE bit1=1 gives soft_clr_o=1 for one cycle and clears busy and done. It is always permitted and has priority over bit0 in the same write, so no start is issued.
- Done: acc_done_i while busy=1 clears busy and sets done on the next edge. acc_done_i while busy=0 is ignored.
- Same-cycle done and W1C: if acc_done_i sets done in the same cycle as a W1C clear of done, the set wins (done=1).
- Config write-protect: a CFG write while busy=1 is dropped with rsp_err_o=1. CFG reads are always allowed.
- irq_o is registered: irq_o = done && IRQ_EN[0], updated one cycle after either term changes.
- Status reads are snapshots taken at the accept edge.
- Reset mid-transaction drops any pending response and clears busy/done without emitting any pulse.

Test Plan:
- Reset, then read addr 1, 2, 3..6 -> all rdata=0, err=0; busy_o=irq_o=0.
- Write CFG[2]=0xDEADBEEF, then read addr 5 -> rdata=0xDEADBEEF; cfg_o[95:64]=0xDEADBEEF, all other config slices 0.
- Write IRQ_EN=1; write CORE=0x1 -> start_o high exactly 1 cycle, busy_o=1. Write CFG[0]=5 -> err=1, cfg_o[31:0] unchanged. Pulse acc_done_i -> STATUS reads 0x2, irq_o=1. Write STATUS=0x2 -> STATUS reads 0, irq_o=0.
- Second CORE=0x1 while busy -> err=1, no start_o pulse. Then CORE=0x3 -> soft_clr_o pulse, no start_o, busy=0, done=0.
- Hold rsp_ready_i=0 for 5 cycles after a read -> req_ready_o=0 and rsp_rdata_o stable. Then random back-to-back traffic with rsp_ready_i=1 -> one accept per cycle, responses in order.
- Read addr 7..15 with NumCfg=4 -> err=1, rdata=0. acc_done_i asserted in the same cycle as a W1C accept -> done remains 1.
